// File: rtl/demod_mc_top.sv
// rtl/demod_mc_top.sv - multi-channel interleaved FM discriminator between I/Q input FIFOs and a tagged output FIFO
// Optional feature: define DEMOD_SAT_EN to saturate the narrowed result instead of wrapping it.

module demod_mc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    // Show-ahead head; forced to zero while empty so the output is defined from reset.
    assign dout  = empty ? '0 : mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (!do_wr && do_rd) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= din;
    end
endmodule

module demod_mc_top #(
    parameter int DATA_WIDTH       = 32,
    parameter int FIFO_BUFFER_SIZE = 32,
    parameter int NUM_CH           = 4,
    parameter int SHIFT            = 10,
    localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         I_full,
    input  logic                         I_wr_en,
    input  logic signed [DATA_WIDTH-1:0] I_din,
    output logic                         Q_full,
    input  logic                         Q_wr_en,
    input  logic signed [DATA_WIDTH-1:0] Q_din,
    input  logic                         out_rd_en,
    output logic                         out_empty,
    output logic signed [DATA_WIDTH-1:0] out_dout,
    output logic [CH_W-1:0]              out_ch
);
    localparam int PW  = 2 * DATA_WIDTH;
    localparam int DW2 = PW + 1;

    logic signed [DATA_WIDTH-1:0] i_dout;
    logic signed [DATA_WIDTH-1:0] q_dout;
    logic                         i_empty;
    logic                         q_empty;
    logic                         out_full;
    logic                         out_wr_en;
    logic [DATA_WIDTH+CH_W-1:0]   out_fifo_dout;
    logic                         adv;
    logic                         pop;

    logic [CH_W-1:0]              ch_cnt;
    logic signed [DATA_WIDTH-1:0] prev_i [NUM_CH];
    logic signed [DATA_WIDTH-1:0] prev_q [NUM_CH];

    logic                         s1_valid;
    logic signed [DATA_WIDTH-1:0] s1_i;
    logic signed [DATA_WIDTH-1:0] s1_q;
    logic signed [DATA_WIDTH-1:0] s1_pi;
    logic signed [DATA_WIDTH-1:0] s1_pq;
    logic [CH_W-1:0]              s1_ch;

    logic                         s2_valid;
    logic signed [PW-1:0]         s2_p0;
    logic signed [PW-1:0]         s2_p1;
    logic [CH_W-1:0]              s2_ch;

    logic                         s3_valid;
    logic signed [DATA_WIDTH-1:0] s3_y;
    logic [CH_W-1:0]              s3_ch;

    logic signed [DW2-1:0]        diff;
    logic signed [DATA_WIDTH-1:0] s3_next;

    demod_mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_i_fifo (
        .clock(clock), .reset(reset),
        .wr_en(I_wr_en), .din(I_din), .full(I_full),
        .rd_en(pop), .dout(i_dout), .empty(i_empty)
    );

    demod_mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_q_fifo (
        .clock(clock), .reset(reset),
        .wr_en(Q_wr_en), .din(Q_din), .full(Q_full),
        .rd_en(pop), .dout(q_dout), .empty(q_empty)
    );

    demod_mc_fifo #(.WIDTH(DATA_WIDTH + CH_W), .DEPTH(FIFO_BUFFER_SIZE)) u_out_fifo (
        .clock(clock), .reset(reset),
        .wr_en(out_wr_en), .din({s3_ch, s3_y}), .full(out_full),
        .rd_en(out_rd_en), .dout(out_fifo_dout), .empty(out_empty)
    );

    assign out_ch   = out_fifo_dout[DATA_WIDTH+CH_W-1:DATA_WIDTH];
    assign out_dout = out_fifo_dout[DATA_WIDTH-1:0];

    // One global advance: the whole pipeline freezes only when a valid result cannot be written.
    assign adv       = !(s3_valid && out_full);
    assign pop       = !i_empty && !q_empty && adv;
    assign out_wr_en = s3_valid && !out_full;

    // History registers are written on the pop edge, so the next pop of the same channel
    // (back-to-back when NUM_CH=1) already reads the new value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                prev_i[c] <= '0;
                prev_q[c] <= '0;
            end
        end else if (pop) begin
            prev_i[ch_cnt] <= i_dout;
            prev_q[ch_cnt] <= q_dout;
            ch_cnt         <= (ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_pi    <= '0;
            s1_pq    <= '0;
            s1_ch    <= '0;
        end else if (adv) begin
            s1_valid <= pop;
            if (pop) begin
                s1_i  <= i_dout;
                s1_q  <= q_dout;
                s1_pi <= prev_i[ch_cnt];
                s1_pq <= prev_q[ch_cnt];
                s1_ch <= ch_cnt;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_p0    <= '0;
            s2_p1    <= '0;
            s2_ch    <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_p0    <= s1_i * s1_pq;
            s2_p1    <= s1_q * s1_pi;
            s2_ch    <= s1_ch;
        end
    end

    // One extra bit so the difference of two full-range products cannot overflow.
    assign diff = $signed({s2_p0[PW-1], s2_p0}) - $signed({s2_p1[PW-1], s2_p1});

`ifdef DEMOD_SAT_EN
    logic signed [DW2-1:0] shifted;
    assign shifted = diff >>> SHIFT;

    always_comb begin
        s3_next = shifted[DATA_WIDTH-1:0];
        if (shifted[DW2-1:DATA_WIDTH-1] != {(DW2-DATA_WIDTH+1){shifted[DW2-1]}}) begin
            s3_next = shifted[DW2-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign s3_next = DATA_WIDTH'(diff >>> SHIFT);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_y     <= '0;
            s3_ch    <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            s3_y     <= s3_next;
            s3_ch    <= s2_ch;
        end
    end
endmodule

// File: tb/tb_demod_mc_top.sv
// tb/tb_demod_mc_top.sv - self-checking bench for demod_mc_top (two configurations, queue model)
module tb_demod_mc_top;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // A: 2 channels, no shift, depth 32
    logic          a_i_full, a_q_full, a_empty;
    logic          a_i_wr = 1'b0, a_q_wr = 1'b0, a_rd = 1'b0;
    logic [DW-1:0] a_i_din = '0, a_q_din = '0, a_dout;
    logic [0:0]    a_ch;

    // B: 1 channel, shift 2, depth 4
    logic          b_i_full, b_q_full, b_empty;
    logic          b_i_wr = 1'b0, b_q_wr = 1'b0, b_rd = 1'b0;
    logic [DW-1:0] b_i_din = '0, b_q_din = '0, b_dout;
    logic [0:0]    b_ch;

    demod_mc_top #(.DATA_WIDTH(DW), .FIFO_BUFFER_SIZE(32), .NUM_CH(2), .SHIFT(0)) dut_a (
        .clock(clock), .reset(reset),
        .I_full(a_i_full), .I_wr_en(a_i_wr), .I_din(a_i_din),
        .Q_full(a_q_full), .Q_wr_en(a_q_wr), .Q_din(a_q_din),
        .out_rd_en(a_rd), .out_empty(a_empty), .out_dout(a_dout), .out_ch(a_ch)
    );

    demod_mc_top #(.DATA_WIDTH(DW), .FIFO_BUFFER_SIZE(4), .NUM_CH(1), .SHIFT(2)) dut_b (
        .clock(clock), .reset(reset),
        .I_full(b_i_full), .I_wr_en(b_i_wr), .I_din(b_i_din),
        .Q_full(b_q_full), .Q_wr_en(b_q_wr), .Q_din(b_q_din),
        .out_rd_en(b_rd), .out_empty(b_empty), .out_dout(b_dout), .out_ch(b_ch)
    );

    // Model state: per-channel previous sample and expected {ch, data} streams.
    int            a_pi [2] = '{default: 0};
    int            a_pq [2] = '{default: 0};
    int            a_c = 0;
    int            b_pi = 0, b_pq = 0;
    logic [DW:0]   exp_a [$];
    logic [DW:0]   got_a [$];
    logic [DW:0]   exp_b [$];
    int            got_b_n = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] narrow(input longint d, input int sh);
        longint s;
        s = d >>> sh;
`ifdef DEMOD_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[DW-1:0];
    endfunction

    task automatic model_a(input int i, input int q);
        longint d;
        d = longint'(i) * longint'(a_pq[a_c]) - longint'(q) * longint'(a_pi[a_c]);
        exp_a.push_back({a_c[0], narrow(d, 0)});
        a_pi[a_c] = i;
        a_pq[a_c] = q;
        a_c = (a_c + 1) % 2;
    endtask

    task automatic model_b(input int i, input int q);
        longint d;
        d = longint'(i) * longint'(b_pq) - longint'(q) * longint'(b_pi);
        exp_b.push_back({1'b0, narrow(d, 2)});
        b_pi = i;
        b_pq = q;
    endtask

    task automatic push_a(input int i, input int q);
        @(posedge clock); #1;
        a_i_wr = 1'b1; a_q_wr = 1'b1;
        a_i_din = i[DW-1:0]; a_q_din = q[DW-1:0];
        model_a(i, q);
    endtask

    task automatic idle_a();
        @(posedge clock); #1;
        a_i_wr = 1'b0; a_q_wr = 1'b0;
    endtask

    task automatic drain_a(input int budget);
        int k = 0;
        while (exp_a.size() != 0 && k < budget) begin
            @(posedge clock);
            k++;
        end
        check("a_drain_complete", exp_a.size(), 0);
        @(posedge clock); #1;
        check("a_empty_after_drain", a_empty, 1);
    endtask

    always @(negedge clock) begin
        logic [DW:0] e;
        if (!reset && a_rd && !a_empty) begin
            got_a.push_back({a_ch, a_dout});
            if (exp_a.size() == 0) begin
                check("a_unexpected_output", {a_ch, a_dout}, -1);
            end else begin
                e = exp_a.pop_front();
                check("a_stream", {a_ch, a_dout}, e);
            end
        end
    end

    always @(negedge clock) begin
        logic [DW:0] e;
        if (!reset && b_rd && !b_empty) begin
            got_b_n++;
            if (exp_b.size() == 0) begin
                check("b_unexpected_output", {b_ch, b_dout}, -1);
            end else begin
                e = exp_b.pop_front();
                check("b_stream", {b_ch, b_dout}, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n_acc;
        logic [DW:0] sat_exp;

        repeat (3) @(posedge clock);
        #1;
        check("rst_I_full", a_i_full, 0);
        check("rst_Q_full", a_q_full, 0);
        check("rst_out_empty", a_empty, 1);
        check("rst_out_dout", a_dout, 0);
        check("rst_out_ch", a_ch, 0);
        check("rst_b_out_empty", b_empty, 1);
        reset = 1'b0;
        a_rd  = 1'b1;

        // Basic interleave plus pipeline latency.
        push_a(1, 0); push_a(0, 1); push_a(0, 1); push_a(1, 0);
        idle_a();
        check("latency_not_early", a_empty, 1);
        @(posedge clock); #1;
        check("latency_on_time", a_empty, 0);
        drain_a(50);
        check("basic_count", got_a.size(), 4);
        check("basic_0", got_a[0], 17'h00000);
        check("basic_1", got_a[1], 17'h10000);
        check("basic_2", got_a[2], 17'h0FFFF);
        check("basic_3", got_a[3], 17'h10001);

        // Large cross-product that overflows 16 bits.
        base = got_a.size();
        push_a(32767, 32767); push_a(0, 0); push_a(32767, -32767); push_a(0, 0);
        idle_a();
        drain_a(50);
`ifdef DEMOD_SAT_EN
        sat_exp = 17'h07FFF;
`else
        sat_exp = 17'h00002;
`endif
        check("big_first", got_a[base], 17'h07FFF);
        check("big_narrowed", got_a[base + 2], sat_exp);

        // I present, Q missing: nothing must move.
        base = got_a.size();
        @(posedge clock); #1;
        a_i_wr = 1'b1; a_i_din = 16'd300;
        @(posedge clock); #1;
        a_i_wr = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("q_missing_empty", a_empty, 1);
        check("q_missing_no_out", got_a.size(), base);
        a_q_wr = 1'b1; a_q_din = 16'hFF38;
        model_a(300, -200);
        @(posedge clock); #1;
        a_q_wr = 1'b0;
        drain_a(50);
        check("q_late_out", got_a.size(), base + 1);

        // Backpressure: 40 samples with the output held.
        base = got_a.size();
        a_rd = 1'b0;
        for (int k = 0; k < 40; k++) push_a(k * 37 - 500, 300 - k * 23);
        idle_a();
        repeat (20) @(posedge clock);
        #1;
        check("stall_no_out", got_a.size(), base);
        check("stall_out_nonempty", a_empty, 0);
        check("stall_I_not_full", a_i_full, 0);
        a_rd = 1'b1;
        drain_a(300);
        check("stall_all_delivered", got_a.size(), base + 40);

        // Reset with two samples in flight.
        base = got_a.size();
        push_a(5, 6); push_a(7, 8);
        idle_a();
        reset = 1'b1;
        exp_a.delete();
        a_pi = '{default: 0}; a_pq = '{default: 0}; a_c = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("midrst_empty", a_empty, 1);
        check("midrst_no_out", got_a.size(), base);
        push_a(9, 4);
        idle_a();
        drain_a(50);
        check("midrst_next_ch0_zero", got_a[got_a.size() - 1], 17'h00000);

        // Single channel, shallow FIFOs: fill to full, then drain.
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            b_i_wr = 1'b1; b_q_wr = 1'b1;
            b_i_din = 16'(k * 90 - 400); b_q_din = 16'(350 - k * 70);
            if (!b_i_full) begin
                model_b(k * 90 - 400, 350 - k * 70);
                n_acc++;
            end
        end
        @(posedge clock); #1;
        b_i_wr = 1'b0; b_q_wr = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("b_I_full", b_i_full, 1);
        check("b_Q_full", b_q_full, 1);
        check("b_accepted", n_acc, 11);
        b_rd = 1'b1;
        for (int k = 0; k < 100 && exp_b.size() != 0; k++) @(posedge clock);
        check("b_drain_complete", exp_b.size(), 0);
        check("b_delivered", got_b_n, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
